fram_initiator: RTL

Request-side sequencer that drives the FRAM processing unit's signal interface. It accepts single-word read/write requests over a valid/ready port and issues them as `signal_addr`/`signal_wr`/`signal_oe` plus `data_in`/`attr_in`. It captures `data_out`/`attr_out` into a response FIFO and enforces the FRAM's read-after-write hazard. It sits between a host/loader or test controller and one FRAM instance.

---
 rtl/fram_initiator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fram_initiator.sv
// Request sequencer for one FRAM: issues reads/writes, buffers read data, stalls on RAW and credits.
// Optional FRAM_INITIATOR_RANGE_CHECK_EN drops out-of-range requests and raises a sticky err.
module fram_initiator #(
  parameter int RAM_SIZE   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int RSP_DEPTH  = 4
) (
`ifdef FRAM_INITIATOR_RANGE_CHECK_EN
  output logic                  err,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [ATTR_WIDTH-1:0] req_attr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ATTR_WIDTH-1:0] rsp_attr,
  output logic [ADDR_WIDTH-1:0] signal_addr,
  output logic                  signal_wr,
  output logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ATTR_WIDTH-1:0] attr_in,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [ATTR_WIDTH-1:0] attr_out
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = CW + 1;
  localparam int EW = ATTR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] r_iss_addr;
  logic [DATA_WIDTH-1:0] r_iss_data;
  logic [ATTR_WIDTH-1:0] r_iss_attr;
  logic                  r_iss_wr;
  logic                  r_iss_oe;
  logic                  r_ret_vld;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;
  logic [EW-1:0]         r_mem [RSP_DEPTH];

  logic                  w_push;
  logic                  w_pop;
  logic                  w_raw;
  logic                  w_credit;
  logic                  w_acc;
  logic                  w_issue;
  logic [UW-1:0]         w_used;
  logic [UW-1:0]         w_limit;
  logic [EW-1:0]         w_head;

  assign w_push    = r_ret_vld;
  assign w_pop     = rsp_valid & rsp_ready;
  assign rsp_valid = (r_cnt != '0);

  // Buffered responses plus reads still in the issue/return stages.
  assign w_used   = UW'(r_cnt) + UW'(r_iss_oe) + UW'(r_ret_vld);
  assign w_limit  = UW'(RSP_DEPTH) + UW'(w_pop);
  assign w_credit = (w_used < w_limit);

  assign w_raw = r_iss_wr & ~req_wr &
                 (req_addr == r_iss_addr);

  assign req_ready = rst & ~w_raw &
                     (req_wr | w_credit);
  assign w_acc = req_valid & req_ready;

`ifdef FRAM_INITIATOR_RANGE_CHECK_EN
  localparam int AW1 = ADDR_WIDTH + 1;
  logic w_inr;
  assign w_inr   = ({1'b0, req_addr} < AW1'(RAM_SIZE));
  assign w_issue = w_acc & w_inr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (w_acc & ~w_inr) begin
      err <= 1'b1;
    end
  end
`else
  assign w_issue = w_acc;
`endif

  assign w_head   = r_mem[r_rptr];
  assign rsp_data = w_head[DATA_WIDTH-1:0];
  assign rsp_attr = w_head[EW-1:DATA_WIDTH];

  assign signal_addr = r_iss_addr;
  assign signal_wr   = r_iss_wr;
  assign signal_oe   = r_iss_oe;
  assign data_in     = r_iss_data;
  assign attr_in     = r_iss_attr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_iss_wr   <= 1'b0;
      r_iss_oe   <= 1'b0;
      r_iss_addr <= '0;
      r_iss_data <= '0;
      r_iss_attr <= '0;
      r_ret_vld  <= 1'b0;
    end else begin
      r_iss_wr   <= w_issue & req_wr;
      r_iss_oe   <= w_issue & ~req_wr;
      r_iss_addr <= w_issue ? req_addr : '0;
      r_iss_data <= (w_issue & req_wr) ? req_data : '0;
      r_iss_attr <= (w_issue & req_wr) ? req_attr : '0;
      r_ret_vld  <= r_iss_oe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {attr_out, data_out};
  end

endmodule
